sipo_xr: RTL and testbench

Parametrised serial-in/parallel-out loader for complex X samples feeding the PE array. It accepts a valid/ready sample stream and fills a per-PE register file of REG_DEPTH entries, either PE by PE or broadcast to all PEs. It then holds the loaded set and presents the head entry of every PE in parallel. On request it rotates all channels in lockstep, so PEs can replay their registers cyclically without reloading.

---
 rtl/sipo_xr_pkg.sv | 10 +
 rtl/srl_rot.sv | 30 +++
 rtl/sipo_xr.sv | 143 ++++++++++++++
 tb/tb_sipo_xr.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_xr_pkg.sv
// Shared types for the sipo_xr sample loader.
package sipo_xr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_KEEP = 2'd2
  } state_e;

endpackage

// File: rtl/srl_rot.sv
// Per-PE shift register: entries enter at the tail, the head is the oldest.
// With rot set, a shift feeds the head back into the tail instead of din.
module srl_rot #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             ce,
  input  logic             rot,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_nxt
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is intentionally unreset so it can map onto SRL primitives.
  always_ff @(posedge clk) begin
    if (ce) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        mem_q[i] <= mem_q[i+1];
      end
      mem_q[DEPTH-1] <= rot ? mem_q[0] : din;
    end
  end

  assign dout     = mem_q[0];
  assign dout_nxt = mem_q[1];

endmodule

// File: rtl/sipo_xr.sv
// Serial-in/parallel-out loader of complex samples into per-PE register files,
// with lockstep rotation of all channels once the set is held.
module sipo_xr
  import sipo_xr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PE_NUM     = 8,
  parameter int unsigned REG_DEPTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           bcast,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [2*DATA_WIDTH-1:0]        s_in,
  input  logic                           rot_en,
  output logic [PE_NUM*2*DATA_WIDTH-1:0] p_out,
  output logic                           p_valid,
  output logic                           load_done,
  output logic                           busy
);

  localparam int unsigned SAMPLE_W       = 2 * DATA_WIDTH;
  localparam int unsigned REG_ADDR_WIDTH = $clog2(REG_DEPTH);
  localparam int unsigned PE_ADDR_WIDTH  = $clog2(PE_NUM);

  state_e                      state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0]   reg_cnt_q, reg_cnt_d;
  logic [PE_ADDR_WIDTH-1:0]    pe_cnt_q, pe_cnt_d;
  logic                        bcast_q, bcast_d;
  logic                        s_ready_q, busy_q, p_valid_q, load_done_q;
  logic [PE_NUM*SAMPLE_W-1:0]  p_out_q, p_out_d;
  logic                        accept, last_acc, rot;
  logic [PE_NUM-1:0]           ce;
  logic [SAMPLE_W-1:0]         head     [PE_NUM];
  logic [SAMPLE_W-1:0]         head_nxt [PE_NUM];

  // Next-state, counter and shift-control decode.
  always_comb begin
    state_d   = state_q;
    reg_cnt_d = reg_cnt_q;
    pe_cnt_d  = pe_cnt_q;
    bcast_d   = bcast_q;
    accept    = 1'b0;
    last_acc  = 1'b0;
    rot       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          reg_cnt_d = '0;
          pe_cnt_d  = '0;
          bcast_d   = bcast;
        end
      end
      ST_LOAD: begin
        accept = s_valid && s_ready_q;
        if (accept) begin
          if (reg_cnt_q == REG_ADDR_WIDTH'(REG_DEPTH - 1)) begin
            reg_cnt_d = '0;
            if (bcast_q || pe_cnt_q == PE_ADDR_WIDTH'(PE_NUM - 1)) begin
              last_acc = 1'b1;
              state_d  = ST_KEEP;
            end else begin
              pe_cnt_d = PE_ADDR_WIDTH'(pe_cnt_q + 1'b1);
            end
          end else begin
            reg_cnt_d = REG_ADDR_WIDTH'(reg_cnt_q + 1'b1);
          end
        end
      end
      ST_KEEP: begin
        if (start) begin
          state_d   = ST_LOAD;
          reg_cnt_d = '0;
          pe_cnt_d  = '0;
          bcast_d   = bcast;
        end else begin
          rot = rot_en;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < int'(PE_NUM); g++) begin : g_pe
    assign ce[g] = rot || (accept && (bcast_q || pe_cnt_q == PE_ADDR_WIDTH'(g)));

    srl_rot #(
      .WIDTH (SAMPLE_W),
      .DEPTH (REG_DEPTH)
    ) u_srl (
      .clk      (clk),
      .ce       (ce[g]),
      .rot      (rot),
      .din      (s_in),
      .dout     (head[g]),
      .dout_nxt (head_nxt[g])
    );
  end

  // p_out is registered, so it is built from the head each channel will hold after this edge.
  always_comb begin
    p_out_d = '0;
    if (state_d == ST_KEEP) begin
      for (int i = 0; i < int'(PE_NUM); i++) begin
        p_out_d[i*SAMPLE_W +: SAMPLE_W] = ce[i] ? head_nxt[i] : head[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      reg_cnt_q   <= '0;
      pe_cnt_q    <= '0;
      bcast_q     <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      p_valid_q   <= 1'b0;
      load_done_q <= 1'b0;
      p_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      reg_cnt_q   <= reg_cnt_d;
      pe_cnt_q    <= pe_cnt_d;
      bcast_q     <= bcast_d;
      s_ready_q   <= (state_d == ST_LOAD);
      busy_q      <= (state_d == ST_LOAD);
      p_valid_q   <= (state_d == ST_KEEP);
      load_done_q <= last_acc;
      p_out_q     <= p_out_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign p_valid   = p_valid_q;
  assign load_done = load_done_q;
  assign p_out     = p_out_q;

endmodule

// File: tb/tb_sipo_xr.sv
// Self-checking bench for sipo_xr: queue-based channel model, a vector table
// for the broadcast/reload sequence, directed scenarios and random traffic.
module tb_sipo_xr;

  localparam int unsigned DW = 8;
  localparam int unsigned PN = 4;
  localparam int unsigned RD = 4;
  localparam int unsigned SW = 2 * DW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              bcast = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [SW-1:0]     s_in = '0;
  logic              rot_en = 1'b0;
  logic [PN*SW-1:0]  p_out;
  logic              p_valid;
  logic              load_done;
  logic              busy;

  always #5 clk = ~clk;

  sipo_xr #(
    .DATA_WIDTH (DW),
    .PE_NUM     (PN),
    .REG_DEPTH  (RD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bcast     (bcast),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_in      (s_in),
    .rot_en    (rot_en),
    .p_out     (p_out),
    .p_valid   (p_valid),
    .load_done (load_done),
    .busy      (busy)
  );

  // Behavioural model: each PE is a queue whose front is the head.
  logic [SW-1:0] ch [PN][$];
  bit m_load, m_valid, m_done, m_bcast;
  int m_acc;
  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < int'(PN); i++) ch[i].delete();
    m_load = 0; m_valid = 0; m_done = 0; m_bcast = 0; m_acc = 0;
  endfunction

  function automatic void model_step(bit st, bit bc, bit sv, logic [SW-1:0] din, bit rt);
    logic [SW-1:0] t;
    m_done = 0;
    if (m_load) begin
      if (sv) begin
        if (m_bcast) begin
          for (int i = 0; i < int'(PN); i++) ch[i].push_back(din);
        end else begin
          ch[m_acc / int'(RD)].push_back(din);
        end
        m_acc++;
        if (m_acc == (m_bcast ? int'(RD) : int'(PN * RD))) begin
          m_load = 0; m_valid = 1; m_done = 1;
        end
      end
    end else if (st) begin
      for (int i = 0; i < int'(PN); i++) ch[i].delete();
      m_load = 1; m_valid = 0; m_acc = 0; m_bcast = bc;
    end else if (m_valid && rt) begin
      for (int i = 0; i < int'(PN); i++) begin
        t = ch[i].pop_front();
        ch[i].push_back(t);
      end
    end
  endfunction

  function automatic logic [PN*SW-1:0] exp_pout();
    logic [PN*SW-1:0] r = '0;
    if (m_valid) begin
      for (int i = 0; i < int'(PN); i++) r[i*SW +: SW] = ch[i][0];
    end
    return r;
  endfunction

  function automatic void check_all();
    chk("s_ready", 64'(s_ready), 64'(m_load));
    chk("busy", 64'(busy), 64'(m_load));
    chk("p_valid", 64'(p_valid), 64'(m_valid));
    chk("load_done", 64'(load_done), 64'(m_done));
    chk("p_out", 64'(p_out), 64'(exp_pout()));
  endfunction

  task automatic cycle(input bit st, input bit bc, input bit sv, input logic [SW-1:0] din,
                       input bit rt);
    start = st; bcast = bc; s_valid = sv; s_in = din; rot_en = rt;
    @(posedge clk);
    model_step(st, bc, sv, din, rt);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    start = 0; bcast = 0; s_valid = 0; rot_en = 0; s_in = '0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic void chk_heads(string tag, logic [SW-1:0] e3, logic [SW-1:0] e2,
                                    logic [SW-1:0] e1, logic [SW-1:0] e0);
    chk({tag, "_pe3"}, 64'(p_out[4*SW-1:3*SW]), 64'(e3));
    chk({tag, "_pe2"}, 64'(p_out[3*SW-1:2*SW]), 64'(e2));
    chk({tag, "_pe1"}, 64'(p_out[2*SW-1:SW]), 64'(e1));
    chk({tag, "_pe0"}, 64'(p_out[SW-1:0]), 64'(e0));
  endfunction

  typedef struct {
    bit            st, bc, sv, rt;
    logic [SW-1:0] din;
    bit            e_ready, e_pvalid, e_done;
    logic [SW-1:0] e_head;
  } vec_t;

  vec_t vt [16];
  logic [SW-1:0] rot_pe0 [4];
  logic [SW-1:0] rot_pe3 [4];

  initial begin
    // Broadcast load, rotations, start+rot_en reload, stalled reload.
    vt[0]  = '{1, 1, 0, 0, 16'h0000, 1, 0, 0, 16'h0000};
    vt[1]  = '{0, 0, 1, 0, 16'h00A1, 1, 0, 0, 16'h0000};
    vt[2]  = '{0, 0, 1, 0, 16'h00A2, 1, 0, 0, 16'h0000};
    vt[3]  = '{0, 0, 1, 0, 16'h00A3, 1, 0, 0, 16'h0000};
    vt[4]  = '{0, 0, 1, 0, 16'h00A4, 0, 1, 1, 16'h00A1};
    vt[5]  = '{0, 0, 0, 0, 16'h0000, 0, 1, 0, 16'h00A1};
    vt[6]  = '{0, 0, 0, 1, 16'h0000, 0, 1, 0, 16'h00A2};
    vt[7]  = '{0, 0, 1, 1, 16'h0055, 0, 1, 0, 16'h00A3};
    vt[8]  = '{1, 1, 0, 1, 16'h0000, 1, 0, 0, 16'h0000};
    vt[9]  = '{0, 0, 0, 0, 16'h00EE, 1, 0, 0, 16'h0000};
    vt[10] = '{0, 0, 1, 0, 16'h00B1, 1, 0, 0, 16'h0000};
    vt[11] = '{0, 0, 1, 0, 16'h00B2, 1, 0, 0, 16'h0000};
    vt[12] = '{0, 0, 1, 0, 16'h00B3, 1, 0, 0, 16'h0000};
    vt[13] = '{0, 0, 1, 0, 16'h00B4, 0, 1, 1, 16'h00B1};
    vt[14] = '{0, 0, 0, 0, 16'h0000, 0, 1, 0, 16'h00B1};
    vt[15] = '{0, 0, 0, 1, 16'h0000, 0, 1, 0, 16'h00B2};
    rot_pe0 = '{16'h0001, 16'h0002, 16'h0003, 16'h0000};
    rot_pe3 = '{16'h000D, 16'h000E, 16'h000F, 16'h000C};

    // Reset, then idle: nothing may move without start.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 16'h1234, 1);

    // PE-by-PE load on continuous s_valid.
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, SW'(i), 0);
    chk_heads("cont", 16'h000C, 16'h0008, 16'h0004, 16'h0000);

    // Four rotations return every channel to its original head.
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, '0, 1);
      chk("rot_pe0", 64'(p_out[SW-1:0]), 64'(rot_pe0[k]));
      chk("rot_pe3", 64'(p_out[4*SW-1:3*SW]), 64'(rot_pe3[k]));
    end

    // Reload from KEEP with s_valid toggling every other cycle.
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 1, SW'(i), 0);
      cycle(0, 0, 0, 16'hFFFF, 0);
    end
    chk_heads("toggle", 16'h000C, 16'h0008, 16'h0004, 16'h0000);

    // Table-driven broadcast sequence.
    for (int v = 0; v < 16; v++) begin
      cycle(vt[v].st, vt[v].bc, vt[v].sv, vt[v].din, vt[v].rt);
      chk($sformatf("vec%0d_ready", v), 64'(s_ready), 64'(vt[v].e_ready));
      chk($sformatf("vec%0d_pvalid", v), 64'(p_valid), 64'(vt[v].e_pvalid));
      chk($sformatf("vec%0d_done", v), 64'(load_done), 64'(vt[v].e_done));
      for (int p = 0; p < int'(PN); p++) begin
        chk($sformatf("vec%0d_head%0d", v, p), 64'(p_out[p*SW +: SW]), 64'(vt[v].e_head));
      end
    end

    // Reset after 5 accepts aborts the load.
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, SW'(16'h0040 + i), 0);
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 16'h0099, 0);

    // start during LOAD is ignored.
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 16; i++) cycle((i >= 3 && i <= 10), 1, 1, SW'(16'h0100 + i), 0);
    chk_heads("ign_start", 16'h010C, 16'h0108, 16'h0104, 16'h0100);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(15) == 0), 1'($urandom), ($urandom_range(9) < 7),
            SW'($urandom), ($urandom_range(2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
